star_box_writer: RTL and testbench
==================================

// Module: star_box_writer
// PURPOSE
//  Write-side counterpart of the star edge mappers. On a start pulse it latches mostLeft/mostRight/mostTop/mostBottom
//  and walks the bounding box in raster order, writing one pixel per accepted cycle.
//  Outline mode draws the box border; fill mode paints or clears the whole box.
//  Sits between the edge mappers (top/bottom/left/right) and the frame-buffer write port.
// PARAMETERS
//  xSz     8      x coordinate width
//  ySz     7      y coordinate width
//  colSz   3      pixel colour width
//  X_MAX   159    rightmost legal column; mostRight is clamped to it
//  Y_MAX   119    bottom legal row; mostBottom is clamped to it
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  start       in   1      1-cycle request; sampled only in IDLE
//  mode        in   1      0 = outline, 1 = fill; latched with start
//  colour      in   colSz  write colour; latched with start
//  mostLeft    in   xSz    box left edge
//  mostRight   in   xSz    box right edge
//  mostTop     in   ySz    box top edge
//  mostBottom  in   ySz    box bottom edge
//  wr_ready    in   1      frame-buffer port accepts the current write this cycle
//  x           out  xSz    write column
//  y           out  ySz    write row
//  colour_out  out  colSz  write data
//  plot        out  1      write valid
//  busy        out  1      high in LATCH and SCAN
//  done        out  1      1-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; x, y, colour_out, plot, busy and done all 0. Reset mid-SCAN aborts at once with no done pulse.
//  FSM states:
//   - IDLE -start-> LATCH.
//   - LATCH -> SCAN, or -> DONE if invalid.
//   - SCAN -> DONE after the last pixel is accepted.
//   - DONE -> IDLE.
//  LATCH:
//   - Register L, T, colour and mode.
//   - R = min(mostRight, X_MAX); B = min(mostBottom, Y_MAX).
//   - Invalid when L>R or T>B: no writes are made, only the done pulse.
//   - Load x=L, y=T.
//  SCAN:
//   - plot=1 every cycle; x, y and colour_out stay stable until plot&&wr_ready.
//   - On acceptance, advance to the next pixel in raster order; stall while wr_ready=0.
//   - Fill: visit every x in L..R for each row T..B.
//   - Outline, rows T and B: visit every x in L..R.
//   - Outline, interior rows: visit x=L, then jump directly to x=R. When L==R, visit that column once only (no duplicate write).
//   - Last pixel is (R,B). When it is accepted: plot=0 next cycle, state=DONE.
//  Output timing:
//   - done=1 for exactly the DONE cycle; busy=0 in DONE and IDLE.
//   - start while busy is ignored.
//   - Inputs may change after LATCH without effect.
//  Latency (wr_ready held high), start in cycle 0:
//   - First plot in cycle 2.
//   - Pixel count is fill: W*H; outline: 2W + 2(H-2) for H>=2, W for H==1, where W=R-L+1 and H=B-T+1 (outline W==1: H).
//   - done in cycle 2 + pixel count.
//  Widths: counters are xSz/ySz wide. Clamping guarantees that x+1 and y+1 never wrap past X_MAX/Y_MAX.
// TESTING
//  1. Outline, L=10 R=12 T=5 B=7, wr_ready=1.
//     -> 8 writes: (10..12,5), (10,6), (12,6), (10..12,7). done in cycle 10.
//  2. Fill, L=10 R=12 T=5 B=7, colour=0.
//     -> 9 raster writes of colour 0; busy high cycles 1-10; done cycle 11.
//  3. Same box as 1, with wr_ready low for 3 cycles at the 4th write.
//     -> x=10,y=6 is held stable 3 extra cycles; no pixel is skipped or repeated; done 3 cycles later.
//  4. mostRight=200, mostBottom=127, L=158, T=118, fill.
//     -> R clamps to 159, B to 119; writes (158,118) (159,118) (158,119) (159,119).
//  5. L=20 R=15 -> no plot ever; done pulses in cycle 2.
//     Separately, L=R=30, T=0, B=2 outline -> 3 writes.
//  6. reset asserted during SCAN -> next cycle plot=0, busy=0, no done.
//     start during busy -> ignored.

Source files
------------

// File: rtl/star_box_writer.sv
// Box writer: latches a bounding box on start and walks it in raster order,
// emitting one frame-buffer write per accepted cycle in outline or fill mode.
module star_box_writer #(
    parameter int xSz   = 8,
    parameter int ySz   = 7,
    parameter int colSz = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [colSz-1:0] colour,
    input  logic [xSz-1:0]   mostLeft,
    input  logic [xSz-1:0]   mostRight,
    input  logic [ySz-1:0]   mostTop,
    input  logic [ySz-1:0]   mostBottom,
    input  logic             wr_ready,
    output logic [xSz-1:0]   x,
    output logic [ySz-1:0]   y,
    output logic [colSz-1:0] colour_out,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    localparam logic [xSz-1:0] X_LIM = xSz'(X_MAX);
    localparam logic [ySz-1:0] Y_LIM = ySz'(Y_MAX);

    typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} stateType;

    stateType             state;
    logic [xSz-1:0]       leftReg;
    logic [xSz-1:0]       rightReg;
    logic [ySz-1:0]       topReg;
    logic [ySz-1:0]       bottomReg;
    logic [colSz-1:0]     colourReg;
    logic                 modeReg;

    logic                 lastPixel;
    logic                 rowEnd;
    logic                 interiorRow;

    always_comb begin
        lastPixel   = (x == rightReg) && (y == bottomReg);
        rowEnd      = (x == rightReg);
        interiorRow = (y != topReg) && (y != bottomReg);
    end

    // Clamping happens as the box is captured, so the scan counters can
    // never step past the legal frame edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            leftReg    <= '0;
            rightReg   <= '0;
            topReg     <= '0;
            bottomReg  <= '0;
            colourReg  <= '0;
            modeReg    <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        leftReg   <= mostLeft;
                        rightReg  <= (mostRight > X_LIM) ? X_LIM : mostRight;
                        topReg    <= mostTop;
                        bottomReg <= (mostBottom > Y_LIM) ? Y_LIM : mostBottom;
                        colourReg <= colour;
                        modeReg   <= mode;
                        busy      <= 1'b1;
                        state     <= LATCH;
                    end
                end
                LATCH: begin
                    if ((leftReg > rightReg) || (topReg > bottomReg)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x          <= leftReg;
                        y          <= topReg;
                        colour_out <= colourReg;
                        plot       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    // Outline interior rows skip straight from the left to the right edge.
                    if (wr_ready) begin
                        if (lastPixel) begin
                            plot  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (rowEnd) begin
                            x <= leftReg;
                            y <= y + 1'b1;
                        end else if (!modeReg && interiorRow && (x == leftReg)) begin
                            x <= rightReg;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_star_box_writer.sv
// Directed bench for star_box_writer: runs small boxes and compares the write
// sequence, stall behaviour and done/busy timing with hand-derived lists.
module tb_star_box_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [2:0] colour;
    logic [7:0] mostLeft;
    logic [7:0] mostRight;
    logic [6:0] mostTop;
    logic [6:0] mostBottom;
    logic       wr_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    int expX[$];
    int expY[$];
    int gotX[$];
    int gotY[$];
    int gotC[$];
    int doneCycle;
    int busyCnt;

    star_box_writer dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .colour(colour),
        .mostLeft(mostLeft), .mostRight(mostRight), .mostTop(mostTop),
        .mostBottom(mostBottom), .wr_ready(wr_ready), .x(x), .y(y),
        .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic addExp(input int ex, input int ey);
        expX.push_back(ex);
        expY.push_back(ey);
    endtask

    // Runs one job from cycle 0 (start high); stalls wr_ready for stallLen
    // cycles when write index stallIdx is presented; optionally re-pulses
    // start with a different box at cycle restartAt.
    task automatic applyStimulus(input string name, input logic m, input int col,
                                 input int l, input int r, input int t, input int b,
                                 input int stallIdx, input int stallLen, input int restartAt);
        int cycle;
        int nAcc;
        int stallCnt;
        bit doneSeen;
        gotX.delete(); gotY.delete(); gotC.delete();
        doneCycle = -1; busyCnt = 0; nAcc = 0; stallCnt = 0; doneSeen = 0;
        mode = m; colour = 3'(col);
        mostLeft = 8'(l); mostRight = 8'(r); mostTop = 7'(t); mostBottom = 7'(b);
        wr_ready = 1'b1;
        start = 1'b1;
        cycle = 0;
        @(posedge clk); #1;
        cycle = 1;
        start = 1'b0;
        while (cycle < 80 && !doneSeen) begin
            if (cycle == restartAt) begin
                start = 1'b1; mostLeft = 8'd0; mostRight = 8'd3;
                mostTop = 7'd0; mostBottom = 7'd3; mode = 1'b1; colour = 3'd7;
            end else begin
                start = 1'b0;
            end
            if (plot && nAcc == stallIdx && stallCnt < stallLen) begin
                wr_ready = 1'b0;
                stallCnt++;
                checkOutput({name, " stallX"}, x, expX[nAcc]);
                checkOutput({name, " stallY"}, y, expY[nAcc]);
            end else begin
                wr_ready = 1'b1;
            end
            if (busy) busyCnt++;
            if (done) begin
                doneCycle = cycle;
                doneSeen = 1;
            end
            if (plot && wr_ready) begin
                gotX.push_back(x); gotY.push_back(y); gotC.push_back(colour_out);
                nAcc++;
            end
            @(posedge clk); #1;
            cycle++;
        end
        start = 1'b0;
        wr_ready = 1'b1;
        checkOutput({name, " doneSeen"}, doneSeen, 1);
        checkOutput({name, " count"}, gotX.size(), expX.size());
        for (int i = 0; i < expX.size() && i < gotX.size(); i++) begin
            checkOutput($sformatf("%s px%0d.x", name, i), gotX[i], expX[i]);
            checkOutput($sformatf("%s px%0d.y", name, i), gotY[i], expY[i]);
            checkOutput($sformatf("%s px%0d.c", name, i), gotC[i], col);
        end
        checkOutput({name, " doneAfter"}, done, 0);
        checkOutput({name, " busyAfter"}, busy, 0);
        checkOutput({name, " plotAfter"}, plot, 0);
        expX.delete(); expY.delete();
    endtask

    initial begin
        int doneHits;
        reset = 1'b1; start = 1'b0; mode = 1'b0; colour = 3'd0;
        mostLeft = '0; mostRight = '0; mostTop = '0; mostBottom = '0; wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst x", x, 0);
        checkOutput("rst y", y, 0);
        checkOutput("rst colour", colour_out, 0);
        checkOutput("rst plot", plot, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: outline 3x3
        addExp(10,5); addExp(11,5); addExp(12,5); addExp(10,6);
        addExp(12,6); addExp(10,7); addExp(11,7); addExp(12,7);
        applyStimulus("outline", 1'b0, 5, 10, 12, 5, 7, -1, 0, -1);
        checkOutput("outline doneCycle", doneCycle, 10);
        checkOutput("outline busyCnt", busyCnt, 9);

        // 2: fill 3x3, colour 0
        for (int yy = 5; yy <= 7; yy++)
            for (int xx = 10; xx <= 12; xx++) addExp(xx, yy);
        applyStimulus("fill", 1'b1, 0, 10, 12, 5, 7, -1, 0, -1);
        checkOutput("fill doneCycle", doneCycle, 11);
        checkOutput("fill busyCnt", busyCnt, 10);

        // 3: outline with a 3-cycle stall on the 4th write
        addExp(10,5); addExp(11,5); addExp(12,5); addExp(10,6);
        addExp(12,6); addExp(10,7); addExp(11,7); addExp(12,7);
        applyStimulus("stall", 1'b0, 2, 10, 12, 5, 7, 3, 3, -1);
        checkOutput("stall doneCycle", doneCycle, 13);

        // 4: clamping at the frame corner
        addExp(158,118); addExp(159,118); addExp(158,119); addExp(159,119);
        applyStimulus("clamp", 1'b1, 6, 158, 200, 118, 127, -1, 0, -1);
        checkOutput("clamp doneCycle", doneCycle, 6);

        // 5: invalid box, then a single-column outline
        applyStimulus("invalid", 1'b0, 1, 20, 15, 3, 4, -1, 0, -1);
        checkOutput("invalid doneCycle", doneCycle, 2);
        addExp(30,0); addExp(30,1); addExp(30,2);
        applyStimulus("column", 1'b0, 4, 30, 30, 0, 2, -1, 0, -1);
        checkOutput("column doneCycle", doneCycle, 5);

        // 6a: start while busy is ignored, input changes after capture ignored
        addExp(10,5); addExp(11,5); addExp(12,5); addExp(10,6);
        addExp(12,6); addExp(10,7); addExp(11,7); addExp(12,7);
        applyStimulus("restart", 1'b0, 3, 10, 12, 5, 7, -1, 0, 4);
        checkOutput("restart doneCycle", doneCycle, 10);
        @(posedge clk); #1;
        checkOutput("restart idle busy", busy, 0);

        // 6b: reset in the middle of a scan
        mode = 1'b1; colour = 3'd5; mostLeft = 8'd10; mostRight = 8'd12;
        mostTop = 7'd5; mostBottom = 7'd7; wr_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midscan plot", plot, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort plot", plot, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        doneHits = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || plot || busy) doneHits++;
            @(posedge clk); #1;
        end
        checkOutput("abort quiet", doneHits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
